noc_traffic_gen: RTL and testbench
==================================

Name: noc_traffic_gen

Overview:
- Parametrised per-node NoC traffic injector that replaces the fixed per-node output buffer modules.
- Generates the all-to-all destination sweep procedurally: every destination except self, in descending order.
- Streams flits into the node's router local input port over a valid/ready handshake.
- Adds backpressure, a programmable inter-flit gap, repeated bursts, restart and status outputs.

Parameters:
- DATA_W, 20: flit width; must be ≥ 20.
- NUM_NODES, 16: node count; 2..16.
- SRC_ID, 9: this node's ID; 0..NUM_NODES-1.
- GAP_CYCLES, 0: idle cycles inserted after each accepted flit; 0 means back-to-back.
- NUM_BURSTS, 1: number of full sweeps; 0 means continuous until enable falls at a burst boundary.
- CNT_W, 16: width of the accepted-flit counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-low reset.
- enable, input, 1: level; permits presentation of new flits.
- restart, input, 1: one-cycle pulse; clears done/counters, returns to IDLE.
- out_ready, input, 1: router accepts flit this cycle.
- dataout, output, DATA_W: flit.
- out_valid, output, 1: flit valid.
- busy, output, 1: state is XFER or GAP.
- done, output, 1: all bursts complete (sticky).
- flit_count, output, CNT_W: accepted flits since reset or restart; wraps.

Behaviour:
- Flit format:
  - [DATA_W-1:12] = SRC_ID, zero-extended.
  - [11:8] = burst index mod 16.
  - [7:4] = dest.
  - [3:0] = dest.
  - Example: SRC_ID=9, burst 0, dest 15 -> 20'h090FF.
- Dest sequence per burst: NUM_NODES-1 down to 0, skipping SRC_ID.
  - FLITS_PER_BURST = NUM_NODES-1.
  - The skip happens combinationally in next-dest logic. No cycle is spent on the self destination.
- Reset (rst=0, async):
  - State IDLE; dataout=0, out_valid=0, busy=0, done=0, flit_count=0.
  - Dest pointer = first dest; burst index = 0.
- All outputs are registered.
- States: IDLE, XFER, GAP, DONE.
- IDLE:
  - enable=1 at edge k -> load first flit, out_valid=1 from edge k (1-cycle latency), go to XFER.
  - enable=0 -> stay, out_valid=0.
- XFER, flit presented:
  - out_valid stays 1 and dataout stays stable until out_valid & out_ready at an edge. Enable falling does not withdraw a presented flit.
  - On transfer, flit_count+1.
  - Last flit of last burst accepted -> DONE, out_valid=0.
  - Otherwise, GAP_CYCLES>0 -> GAP, out_valid=0, gap counter = GAP_CYCLES-1.
  - Otherwise, GAP_CYCLES=0 and enable=1 -> next flit loaded on the same edge (full throughput, one flit per cycle).
  - Otherwise, GAP_CYCLES=0 and enable=0 -> XFER with out_valid=0 (paused); next flit loaded at the first edge with enable=1.
- GAP:
  - Count down.
  - At 0 with enable=1 -> present the next flit in XFER.
  - At 0 with enable=0 -> paused XFER as above.
- Burst boundary:
  - After the last dest (0, or 1 when SRC_ID=0) is accepted, dest wraps to the first dest and burst index +1.
  - NUM_BURSTS=0: never enters DONE. The burst index wraps mod 16.
- DONE:
  - done=1, out_valid=0, busy=0.
  - enable is ignored.
  - Leaves only on restart or reset.
- restart:
  - Synchronous, highest priority after rst, in any state.
  - Goes to IDLE; clears done, flit_count, pointers and out_valid.
  - A flit presented in the same cycle is dropped, not counted, even if out_ready=1.
- Simultaneous out_ready=1 with out_valid=0: no effect.
- Reset mid-burst: everything returns to reset values; the next enable restarts from burst 0, first dest.

Decomposition:
- Package noc_tg_pkg:
  - state enum {IDLE, XFER, GAP, DONE}.
  - Flit field offsets (SRC_LSB=12, BURST_LSB=8, DEST_HI_LSB=4, DEST_LO_LSB=0).
  - Function next_dest(cur, src_id, num_nodes), returning the wrap flag.
  - Function build_flit(src, burst, dest).
- Sub-module noc_tg_dest_seq: dest pointer register, skip-self and wrap logic, burst counter. It takes an advance strobe.
- FSM, gap counter, handshake and flit_count live in the top level.

Test Plan:
- Defaults, enable=1, out_ready=1 -> 15 consecutive flits 090FF, 090EE, ... 090AA, 09088, ... 09000 (no 09099).
  - First out_valid 1 cycle after enable is sampled.
  - Then done=1, flit_count=15, out_valid stays 0.
- out_ready toggled 1,0,0,1 on flit 090EE -> dataout held at 090EE with out_valid=1 through the stall; no duplicate or skipped flit; flit_count increments once.
- GAP_CYCLES=2 -> out_valid pattern 1,0,0,1,0,0... with out_ready=1; 15 flits over 43 cycles.
- NUM_BURSTS=2 -> 30 flits; flit 16 is 091FF, the last is 09100; then done.
- SRC_ID=0 -> sequence 000FF .. 00011 (15 flits, no 00000).
  - enable dropped mid-burst with GAP_CYCLES=0 -> current flit completes, out_valid=0 until enable returns, and the sequence resumes at the next dest.
- rst pulsed low during flit 5 -> outputs immediately 0.
  - restart in DONE -> done=0, flit_count=0, and the next enable replays from 090FF.

Source files
------------

// File: rtl/noc_tg_pkg.sv
// noc_tg_pkg: state encoding, flit layout and destination-sweep helpers shared by the
// noc_traffic_gen top and its destination sequencer.
package noc_tg_pkg;
    typedef enum logic [1:0] {IDLE, XFER, GAP, DONE} state_e;
    localparam int SRC_LSB = 12;
    localparam int BURST_LSB = 8;
    localparam int DEST_HI_LSB = 4;
    localparam int DEST_LO_LSB = 0;
    typedef struct packed {
        logic       wrap;
        logic [3:0] dest;
    } dest_step_t;
    function automatic logic [3:0] first_dest(input logic [3:0] src_id, input int num_nodes);
        return (src_id == 4'(num_nodes - 1)) ? 4'(num_nodes - 2) : 4'(num_nodes - 1);
    endfunction
    // The sweep ends on 0, or on 1 when this node is 0; self is stepped over in the same hop.
    function automatic dest_step_t next_dest(input logic [3:0] cur, input logic [3:0] src_id,
                                             input int num_nodes);
        dest_step_t r;
        logic [3:0] last;
        last = (src_id == 4'd0) ? 4'd1 : 4'd0;
        r.wrap = (cur == last);
        r.dest = r.wrap ? first_dest(src_id, num_nodes)
                        : ((cur - 4'd1 == src_id) ? cur - 4'd2 : cur - 4'd1);
        return r;
    endfunction
    function automatic logic [15:0] build_flit(input logic [3:0] src, input logic [3:0] burst,
                                               input logic [3:0] dest);
        logic [15:0] f;
        f = '0;
        f[SRC_LSB+:4] = src;
        f[BURST_LSB+:4] = burst;
        f[DEST_HI_LSB+:4] = dest;
        f[DEST_LO_LSB+:4] = dest;
        return f;
    endfunction
endpackage

// File: rtl/noc_tg_dest_seq.sv
// noc_tg_dest_seq: holds the next destination to load and the burst it belongs to;
// advancing steps down the sweep, skipping self, and bumps the burst on wrap.
module noc_tg_dest_seq
    import noc_tg_pkg::*;
#(
    parameter int NUM_NODES  = 16,
    parameter int SRC_ID     = 9,
    parameter int NUM_BURSTS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       adv_i,
    output logic [3:0] dest_o,
    output logic [3:0] burst_o,
    output logic       final_o
);
    localparam int BURST_W = NUM_BURSTS > 16 ? $clog2(NUM_BURSTS) : 4;
    localparam logic [3:0] SRC = 4'(SRC_ID);
    localparam logic [3:0] FIRST = first_dest(SRC, NUM_NODES);
    logic [3:0]         dest_q;
    logic [BURST_W-1:0] burst_q;
    dest_step_t         step_d;
    always_comb step_d = next_dest(dest_q, SRC, NUM_NODES);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dest_q <= FIRST;
            burst_q <= '0;
        end else if (clear_i) begin
            dest_q <= FIRST;
            burst_q <= '0;
        end else if (adv_i) begin
            dest_q <= step_d.dest;
            burst_q <= burst_q + BURST_W'(step_d.wrap);
        end
    end
    assign dest_o = dest_q;
    assign burst_o = burst_q[3:0];
    // Continuous mode (NUM_BURSTS=0) never reaches a final flit.
    assign final_o = step_d.wrap && NUM_BURSTS != 0 && burst_q == BURST_W'(NUM_BURSTS - 1);
endmodule

// File: rtl/noc_traffic_gen.sv
// noc_traffic_gen: per-node all-to-all NoC traffic injector streaming flits to the local
// router port with backpressure, inter-flit gaps, repeated bursts and restart.
module noc_traffic_gen
    import noc_tg_pkg::*;
#(
    parameter int DATA_W     = 20,
    parameter int NUM_NODES  = 16,
    parameter int SRC_ID     = 9,
    parameter int GAP_CYCLES = 0,
    parameter int NUM_BURSTS = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              restart_i,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] dataout_o,
    output logic              out_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  flit_count_o
);
    localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    state_e            state_q;
    logic [DATA_W-1:0] dataout_q;
    logic              valid_q, busy_q, done_q, last_q;
    logic [CNT_W-1:0]  count_q;
    logic [GAP_W-1:0]  gap_q;
    logic [3:0]        dest, burst;
    logic              final_flit, accept_d, load_d;
    noc_tg_dest_seq #(
        .NUM_NODES (NUM_NODES),
        .SRC_ID    (SRC_ID),
        .NUM_BURSTS(NUM_BURSTS)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .clear_i(restart_i),
        .adv_i  (load_d),
        .dest_o (dest),
        .burst_o(burst),
        .final_o(final_flit)
    );
    // A new flit is loaded whenever the output slot is (or is about to be) free and enable is high.
    always_comb begin
        accept_d = state_q == XFER && valid_q && out_ready_i;
        load_d = !restart_i && enable_i &&
                 (state_q == IDLE ||
                  (state_q == XFER && (accept_d ? (!last_q && GAP_CYCLES == 0) : !valid_q)) ||
                  (state_q == GAP && gap_q == '0));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dataout_q <= '0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            last_q <= 1'b0;
            count_q <= '0;
            gap_q <= '0;
        end else if (restart_i) begin
            state_q <= IDLE;
            dataout_q <= '0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            last_q <= 1'b0;
            count_q <= '0;
            gap_q <= '0;
        end else begin
            if (load_d) begin
                dataout_q <= DATA_W'(build_flit(4'(SRC_ID), burst, dest));
                last_q <= final_flit;
            end
            if (accept_d) count_q <= count_q + CNT_W'(1);
            case (state_q)
                IDLE: if (enable_i) begin
                    state_q <= XFER;
                    valid_q <= 1'b1;
                    busy_q <= 1'b1;
                end
                XFER: if (accept_d && last_q) begin
                    state_q <= DONE;
                    valid_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else if (accept_d && GAP_CYCLES != 0) begin
                    state_q <= GAP;
                    valid_q <= 1'b0;
                    gap_q <= GAP_W'(GAP_CYCLES - 1);
                end else if (accept_d || !valid_q) begin
                    valid_q <= enable_i;
                end
                GAP: if (gap_q != '0) begin
                    gap_q <= gap_q - GAP_W'(1);
                end else begin
                    state_q <= XFER;
                    valid_q <= enable_i;
                end
                default: ;
            endcase
        end
    end
    assign dataout_o = dataout_q;
    assign out_valid_o = valid_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign flit_count_o = count_q;
endmodule

// File: tb/tb_noc_traffic_gen.sv
// tb_noc_traffic_gen: five differently parameterised generators share enable/restart/rst and
// are scored against a flit-sequence model derived from the destination sweep rules.
module tb_noc_traffic_gen;
    localparam int NI = 5;
    localparam int NN [NI] = '{16, 16, 16, 3, 2};
    localparam int SR [NI] = '{9, 9, 0, 1, 0};
    localparam int GP [NI] = '{0, 2, 0, 0, 1};
    localparam int NB [NI] = '{1, 1, 2, 0, 3};
    localparam int CW [NI] = '{16, 16, 16, 4, 16};
    localparam int DW [NI] = '{20, 24, 20, 20, 20};
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic restart = 1'b0;
    logic [NI-1:0] rdy = '0;
    logic [NI-1:0] vld, bsy, dn;
    logic [23:0] dout [NI];
    logic [15:0] fc [NI];
    int n_chk = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < NI; g++) begin : gen_dut
        logic [DW[g]-1:0] d;
        logic [CW[g]-1:0] c;
        noc_traffic_gen #(
            .DATA_W(DW[g]), .NUM_NODES(NN[g]), .SRC_ID(SR[g]),
            .GAP_CYCLES(GP[g]), .NUM_BURSTS(NB[g]), .CNT_W(CW[g])
        ) u_dut (
            .clk(clk), .rst(rst), .enable_i(enable), .restart_i(restart),
            .out_ready_i(rdy[g]), .dataout_o(d), .out_valid_o(vld[g]),
            .busy_o(bsy[g]), .done_o(dn[g]), .flit_count_o(c)
        );
        assign dout[g] = 24'(d);
        assign fc[g] = 16'(c);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // idx-th flit overall: burst = idx / per-burst count, dest counts down from NN-1 skipping src.
    function automatic logic [31:0] exp_flit(input int nn, input int src, input int idx);
        int b, d;
        b = idx / (nn - 1);
        d = nn - 1 - idx % (nn - 1);
        if (d <= src) d--;
        return 32'(src * 4096 + (b % 16) * 256 + d * 16 + d);
    endfunction
    int acc [NI] = '{default: 0};
    int gap_m [NI] = '{default: 0};
    int first_v [NI] = '{default: -1};
    int last_hs [NI] = '{default: 0};
    bit started [NI] = '{default: 0};
    bit done_m [NI] = '{default: 0};
    bit exp_v [NI] = '{default: 0};
    bit hold [NI] = '{default: 0};
    logic [23:0] held [NI];
    logic [23:0] first_flit [NI];
    logic [23:0] last_flit [NI];
    int cyc = 0;
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst) begin
                chk($sformatf("rst_valid[%0d]", g), 32'(vld[g]), 32'd0);
                chk($sformatf("rst_data[%0d]", g), 32'(dout[g]), 32'd0);
                chk($sformatf("rst_count[%0d]", g), 32'(fc[g]), 32'd0);
                chk($sformatf("rst_done[%0d]", g), 32'(dn[g]), 32'd0);
                chk($sformatf("rst_busy[%0d]", g), 32'(bsy[g]), 32'd0);
                acc[g] = 0; gap_m[g] = 0; started[g] = 0; done_m[g] = 0;
                exp_v[g] = 0; hold[g] = 0; first_v[g] = -1;
            end else begin
                chk($sformatf("valid[%0d]", g), 32'(vld[g]), 32'(exp_v[g]));
                if (hold[g]) chk($sformatf("hold_data[%0d]", g), 32'(dout[g]), 32'(held[g]));
                chk($sformatf("count[%0d]", g), 32'(fc[g]), 32'(acc[g] % (1 << CW[g])));
                chk($sformatf("done[%0d]", g), 32'(dn[g]), 32'(done_m[g]));
                chk($sformatf("busy[%0d]", g), 32'(bsy[g]), 32'(started[g] && !done_m[g]));
                if (vld[g] && first_v[g] < 0) first_v[g] = cyc;
                hold[g] = 0;
                if (restart) begin
                    acc[g] = 0; gap_m[g] = 0; started[g] = 0; done_m[g] = 0;
                    exp_v[g] = 0; first_v[g] = -1;
                end else if (vld[g] && rdy[g]) begin
                    chk($sformatf("flit[%0d]#%0d", g, acc[g]), 32'(dout[g]), exp_flit(NN[g], SR[g], acc[g]));
                    if (acc[g] == 0) first_flit[g] = dout[g];
                    last_flit[g] = dout[g];
                    last_hs[g] = cyc;
                    acc[g]++;
                    if (NB[g] != 0 && acc[g] == NB[g] * (NN[g] - 1)) begin
                        done_m[g] = 1; exp_v[g] = 0;
                    end else if (GP[g] > 0) begin
                        gap_m[g] = GP[g]; exp_v[g] = 0;
                    end else exp_v[g] = enable;
                end else if (vld[g]) begin
                    exp_v[g] = 1; hold[g] = 1; held[g] = dout[g];
                end else if (done_m[g]) begin
                    exp_v[g] = 0;
                end else if (gap_m[g] > 0) begin
                    gap_m[g]--;
                    exp_v[g] = (gap_m[g] == 0) && enable;
                end else begin
                    exp_v[g] = enable;
                    if (enable) started[g] = 1;
                end
            end
        end
        cyc++;
    end
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) step();
        enable = 1'b1;
        for (int c = 0; c < 60; c++) begin
            rdy = '1;
            rdy[0] = !(c == 2 || c == 3);
            step();
        end
        chk("span0", 32'(last_hs[0] - first_v[0] + 1), 32'd17);
        chk("span1", 32'(last_hs[1] - first_v[1] + 1), 32'd43);
        chk("span2", 32'(last_hs[2] - first_v[2] + 1), 32'd30);
        chk("span4", 32'(last_hs[4] - first_v[4] + 1), 32'd5);
        chk("first0", 32'(first_flit[0]), 32'h090FF);
        chk("last0", 32'(last_flit[0]), 32'h09000);
        chk("last1", 32'(last_flit[1]), 32'h09000);
        chk("first2", 32'(first_flit[2]), 32'h000FF);
        chk("last2", 32'(last_flit[2]), 32'h00111);
        chk("last4", 32'(last_flit[4]), 32'h00211);
        chk("cnt0", 32'(fc[0]), 32'd15);
        chk("cnt2", 32'(fc[2]), 32'd30);
        chk("done_all", 32'({dn[4], dn[2], dn[1], dn[0]}), 32'hF);
        chk("cont_not_done", 32'(dn[3]), 32'd0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_done", 32'(dn[0]), 32'd0);
        chk("restart_cnt", 32'(fc[0]), 32'd0);
        for (int i = 0; i < 50 && fc[0] != 16'd5; i++) step();
        chk("wait_flit5", 32'(fc[0]), 32'd5);
        rst = 1'b0;
        #1;
        chk("async_valid", 32'(vld[0]), 32'd0);
        chk("async_data", 32'(dout[0]), 32'd0);
        chk("async_cnt", 32'(fc[0]), 32'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom % 5) != 0;
            restart = ($urandom % 150) == 0;
            rdy = NI'($urandom);
            rst = ($urandom % 300) != 0;
            step();
        end
        rst = 1'b1;
        restart = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
